// File: rtl/ascon_perm_ctrl_spa.sv
`default_nettype none
// ============================================================================
// Module : ascon_perm_ctrl_spa
// Brief  : Control sequencer for the 16-bit-slice serial Ascon permutation.
//          Define PERM_OUT_REG_EN to get a registered, back-pressured result.
// Rev    : 1.0  initial release
// ============================================================================
module ascon_perm_ctrl_spa #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6,
  parameter int SLICES   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [319:0] state_in,
  output logic [319:0] dp_in,
  output logic         sel1,
  output logic         sel2,
  output logic         sel_cst,
  output logic         done,
  output logic [3:0]   rnd,
  input  logic [319:0] dp_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] state_out
);

  localparam logic [1:0] c_S_LAST = 2'(SLICES - 1);
  localparam logic [3:0] c_LAST_A = 4'(ROUNDS_A - 1);
  localparam logic [3:0] c_LAST_B = 4'(ROUNDS_B - 1);
  localparam logic [3:0] c_BASE_B = 4'(ROUNDS_A - ROUNDS_B);

`ifdef PERM_OUT_REG_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HOLD = 2'd2} state_t;
  localparam state_t c_AFTER_DONE = ST_HOLD;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1} state_t;
  localparam state_t c_AFTER_DONE = ST_IDLE;
`endif

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_s;
  logic [3:0] r_k;
  logic [3:0] r_last;
  logic [3:0] r_base;
  logic       w_accept;

  assign w_accept = in_valid & ~rst & (r_state == ST_IDLE);
  assign dp_in    = state_in;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    sel1        = 1'b0;
    sel2        = 1'b0;
    sel_cst     = 1'b0;
    done        = 1'b0;
    rnd         = 4'd0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (w_accept) begin
          sel1        = 1'b1;
          sel2        = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        rnd     = r_base + r_k;
        sel_cst = (r_s == 2'd0);
        // Last slice of every round reloads the datapath from its feedback.
        if (r_s == c_S_LAST) begin
          sel2 = 1'b1;
          if (r_k == r_last) begin
            done        = 1'b1;
            w_state_nxt = c_AFTER_DONE;
          end
        end
      end
`ifdef PERM_OUT_REG_EN
      ST_HOLD: begin
        if (out_ready) w_state_nxt = ST_IDLE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_s     <= 2'd0;
      r_k     <= 4'd0;
      r_last  <= 4'd0;
      r_base  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_RUN) begin
        r_s <= r_s + 2'd1;
        if (r_s == c_S_LAST) r_k <= r_k + 4'd1;
      end else begin
        r_s <= 2'd0;
        r_k <= 4'd0;
      end
      if (w_accept) begin
        r_last <= mode ? c_LAST_B : c_LAST_A;
        r_base <= mode ? c_BASE_B : 4'd0;
      end
    end
  end

`ifdef PERM_OUT_REG_EN
  logic [319:0] r_state_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_out <= '0;
    end else if (done) begin
      r_state_out <= dp_out;
    end
  end

  assign state_out = r_state_out;
  assign out_valid = (r_state == ST_HOLD);
`else
  // Result is a single-cycle pulse straight from the datapath; no stall path.
  logic w_unused_out_ready;
  assign w_unused_out_ready = out_ready;
  assign state_out          = dp_out;
  assign out_valid          = done;
`endif

endmodule
`default_nettype wire
